// File: rtl/n_to_1_stream_mux.sv
// N-channel valid/ready stream mux with a 1-entry registered output, fixed-select or round-robin
// arbitration, and the grant held on one channel from a packet's first beat to its last.
module n_to_1_stream_mux #(
  parameter int N = 6,
  parameter int W = 8,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rr_mode,
  input  logic [SW-1:0]  sel,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_last,
  input  logic [N-1:0]   in_valid,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_last,
  output logic [SW-1:0]  out_chan,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           sel_err
);

  typedef enum logic {ARB, LOCK} state_t;

  localparam logic [SW:0] NL = N[SW:0];

  state_t              state;
  logic [SW-1:0]       lock_ch;
  logic [SW-1:0]       rr_ptr;
  logic [N-1:0][W-1:0] dat;
  logic                can_load;
  logic                sel_ok;
  logic                cand_vld;
  logic [SW-1:0]       cand;
  logic [SW:0]         idx;
  logic                xfer;

  assign dat      = in_data;
  assign can_load = !out_valid || out_ready;
  assign sel_ok   = {1'b0, sel} < NL;

  // Round-robin scans rr_ptr+1 .. rr_ptr+N modulo N, so the last winner gets lowest priority.
  always_comb begin
    cand_vld = 1'b0;
    cand     = '0;
    idx      = '0;
    if (state == LOCK) begin
      cand_vld = 1'b1;
      cand     = lock_ch;
    end else if (!rr_mode) begin
      if (sel_ok) begin
        cand_vld = 1'b1;
        cand     = sel;
      end
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = {1'b0, rr_ptr} + (SW+1)'(k);
        if (idx >= NL) idx = idx - NL;
        if (!cand_vld && in_valid[idx[SW-1:0]]) begin
          cand_vld = 1'b1;
          cand     = idx[SW-1:0];
        end
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (cand_vld && can_load) in_ready[cand] = 1'b1;
  end

  assign xfer = cand_vld && can_load && in_valid[cand];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ARB;
      lock_ch   <= '0;
      rr_ptr    <= SW'(N-1);
      out_data  <= '0;
      out_last  <= 1'b0;
      out_chan  <= '0;
      out_valid <= 1'b0;
      sel_err   <= 1'b0;
    end else begin
      sel_err <= (state == ARB) && !rr_mode && !sel_ok;
      if (xfer) begin
        out_data  <= dat[cand];
        out_last  <= in_last[cand];
        out_chan  <= cand;
        out_valid <= 1'b1;
        if (in_last[cand]) begin
          state  <= ARB;
          rr_ptr <= cand;
        end else begin
          state   <= LOCK;
          lock_ch <= cand;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_n_to_1_stream_mux.sv
// Directed bench for n_to_1_stream_mux (N=6, W=8) with hand-computed expectations.
module tb_n_to_1_stream_mux;
  localparam int N = 6;
  localparam int W = 8;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           rr_mode;
  logic [SW-1:0]  sel;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_last;
  logic [SW-1:0]  out_chan;
  logic           out_valid;
  logic           out_ready;
  logic           sel_err;

  int checks = 0;
  int failures = 0;

  n_to_1_stream_mux #(.N(N), .W(W)) dut (
    .clk(clk), .rst(rst), .rr_mode(rr_mode), .sel(sel),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_chan(out_chan), .out_valid(out_valid),
    .out_ready(out_ready), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int ch, input logic [7:0] d, input logic l, input logic v);
    in_data[ch*W +: W] = d;
    in_last[ch] = l;
    in_valid[ch] = v;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [7:0] d,
                         input logic [2:0] c, input logic l);
    check({tag, "_valid"}, 32'(out_valid), 32'(v));
    check({tag, "_data"}, 32'(out_data), 32'(d));
    check({tag, "_chan"}, 32'(out_chan), 32'(c));
    check({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    rst = 1'b1; rr_mode = 1'b0; sel = 3'd0; out_ready = 1'b1;
    in_data = '0; in_last = '0; in_valid = '0;
    step(); step();
    chk_out("reset", 1'b0, 8'h00, 3'd0, 1'b0);
    check("reset_sel_err", 32'(sel_err), 32'd0);
    rst = 1'b0;

    // 1: fixed sel=2, 3-beat packet
    sel = 3'd2;
    set_ch(2, 8'hA1, 1'b0, 1'b1); #1;
    check("t1_rdy1", 32'(in_ready), 32'h04);
    step(); chk_out("t1_b1", 1'b1, 8'hA1, 3'd2, 1'b0);
    set_ch(2, 8'hA2, 1'b0, 1'b1);
    step(); chk_out("t1_b2", 1'b1, 8'hA2, 3'd2, 1'b0);
    set_ch(2, 8'hA3, 1'b1, 1'b1);
    step(); chk_out("t1_b3", 1'b1, 8'hA3, 3'd2, 1'b1);
    set_ch(2, 8'h00, 1'b0, 1'b0);
    step(); check("t1_drain", 32'(out_valid), 32'd0);

    // 2: sel switches mid-packet, lock holds on ch2
    set_ch(2, 8'hB1, 1'b0, 1'b1);
    step(); chk_out("t2_b1", 1'b1, 8'hB1, 3'd2, 1'b0);
    sel = 3'd4;
    set_ch(4, 8'hC1, 1'b1, 1'b1);
    set_ch(2, 8'hB2, 1'b0, 1'b1); #1;
    check("t2_rdy2", 32'(in_ready), 32'h04);
    step(); chk_out("t2_b2", 1'b1, 8'hB2, 3'd2, 1'b0);
    set_ch(2, 8'hB3, 1'b1, 1'b1); #1;
    check("t2_rdy3", 32'(in_ready), 32'h04);
    step(); chk_out("t2_b3", 1'b1, 8'hB3, 3'd2, 1'b1);
    set_ch(2, 8'h00, 1'b0, 1'b0); #1;
    check("t2_rdy4", 32'(in_ready), 32'h10);
    step(); chk_out("t2_c1", 1'b1, 8'hC1, 3'd4, 1'b1);
    in_valid = '0;
    step();

    // 3: round-robin from reset, all channels valid with single beats
    rst = 1'b1; step(); rst = 1'b0;
    rr_mode = 1'b1;
    for (int i = 0; i < N; i++) set_ch(i, 8'(8'h10 + i), 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t3_rdy", 32'(in_ready), 32'(6'b1 << (i % N)));
      step();
      chk_out("t3_out", 1'b1, 8'(8'h10 + (i % N)), 3'(i % N), 1'b1);
    end
    in_valid = '0; rr_mode = 1'b0;
    step();

    // 4: backpressure mid-packet on ch3
    sel = 3'd3;
    set_ch(3, 8'hD1, 1'b0, 1'b1);
    step(); chk_out("t4_d1", 1'b1, 8'hD1, 3'd3, 1'b0);
    set_ch(3, 8'hD2, 1'b0, 1'b1);
    step(); chk_out("t4_d2", 1'b1, 8'hD2, 3'd3, 1'b0);
    set_ch(3, 8'hD3, 1'b0, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1; check("t4_stall_rdy", 32'(in_ready), 32'h00);
      step(); chk_out("t4_hold", 1'b1, 8'hD2, 3'd3, 1'b0);
    end
    out_ready = 1'b1; #1;
    check("t4_resume_rdy", 32'(in_ready), 32'h08);
    step(); chk_out("t4_d3", 1'b1, 8'hD3, 3'd3, 1'b0);
    set_ch(3, 8'hD4, 1'b1, 1'b1);
    step(); chk_out("t4_d4", 1'b1, 8'hD4, 3'd3, 1'b1);
    in_valid = '0;
    step(); check("t4_drain", 32'(out_valid), 32'd0);

    // 5: out-of-range select
    sel = 3'd7;
    for (int i = 0; i < N; i++) set_ch(i, 8'(8'h20 + i), 1'b0, 1'b1);
    #1; check("t5_rdy", 32'(in_ready), 32'h00);
    step();
    check("t5_sel_err", 32'(sel_err), 32'd1);
    check("t5_valid", 32'(out_valid), 32'd0);
    check("t5_no_x", 32'($isunknown({out_data, out_last, out_chan})), 32'd0);
    in_valid = '0;
    sel = 3'd1;
    set_ch(1, 8'h11, 1'b1, 1'b1); #1;
    check("t5_rdy_sel1", 32'(in_ready), 32'h02);
    step();
    check("t5_sel_err_clr", 32'(sel_err), 32'd0);
    chk_out("t5_ch1", 1'b1, 8'h11, 3'd1, 1'b1);
    in_valid = '0;
    step();

    // 6: reset during beat 2 of a 4-beat packet on ch5
    sel = 3'd5;
    set_ch(5, 8'hE1, 1'b0, 1'b1);
    step(); chk_out("t6_e1", 1'b1, 8'hE1, 3'd5, 1'b0);
    set_ch(5, 8'hE2, 1'b0, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_valid", 32'(out_valid), 32'd0);
    in_valid = '0;
    rr_mode = 1'b1;
    set_ch(0, 8'h50, 1'b1, 1'b1);
    set_ch(3, 8'h53, 1'b1, 1'b1); #1;
    check("t6_rdy_ch0", 32'(in_ready), 32'h01);
    step(); chk_out("t6_ch0", 1'b1, 8'h50, 3'd0, 1'b1);
    set_ch(0, 8'h00, 1'b0, 1'b0); #1;
    check("t6_rdy_ch3", 32'(in_ready), 32'h08);
    step(); chk_out("t6_ch3", 1'b1, 8'h53, 3'd3, 1'b1);
    in_valid = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
